// File: rtl/cnn_result_writer.sv
// cnn_result_writer: output feature-map write-address generator with a 1-cycle registered write port.
// Optional CNN_RESULT_WRITER_RELU_EN clamps negative results to zero in the write-data register.
module cnn_result_writer #(
    parameter int OUT_W_P  = 3,
    parameter int OUT_H_P  = 2,
    parameter int CH_P     = 2,
    parameter int DATA_W_P = 16,
    parameter int ADDR_W_P = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic [ADDR_W_P-1:0]          base_addr_i,
    input  logic                         valid_i,
    input  logic [DATA_W_P-1:0]          data_i,
    output logic                         ready_o,
    output logic                         we_o,
    output logic [ADDR_W_P-1:0]          waddr_o,
    output logic [DATA_W_P-1:0]          wdata_o,
    output logic [$clog2(OUT_W_P):0]     col_o,
    output logic [$clog2(OUT_H_P):0]     row_o,
    output logic [$clog2(CH_P):0]        ch_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int CW = $clog2(OUT_W_P) + 1;
    localparam int RW = $clog2(OUT_H_P) + 1;
    localparam int HW = $clog2(CH_P) + 1;
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_W_P - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H_P - 1);
    localparam logic [HW-1:0] CH_MAX  = HW'(CH_P - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [HW-1:0]         ch_q;
    logic [ADDR_W_P-1:0]   base_q, off_q, waddr_q;
    logic [DATA_W_P-1:0]   wdata_q, wdata_d;
    logic                  we_q, done_q;
    logic                  accept, col_end, row_end, ch_end, last;

    assign accept  = valid_i & (state_q == RUN);
    assign col_end = col_q == COL_MAX;
    assign row_end = row_q == ROW_MAX;
    assign ch_end  = ch_q == CH_MAX;
    assign last    = col_end & row_end & ch_end;

`ifdef CNN_RESULT_WRITER_RELU_EN
    assign wdata_d = data_i[DATA_W_P-1] ? '0 : data_i;
`else
    assign wdata_d = data_i;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start_i)
            state_d = RUN;
        else if (accept && last)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            base_q  <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= accept;
            done_q  <= accept & last;
            if (accept) begin
                // address is base + running offset; wraps naturally at ADDR_W_P bits
                waddr_q <= base_q + off_q;
                wdata_q <= wdata_d;
                off_q   <= off_q + ADDR_W_P'(1);
                col_q   <= col_end ? '0 : col_q + CW'(1);
                row_q   <= col_end ? (row_end ? '0 : row_q + RW'(1)) : row_q;
                ch_q    <= (col_end & row_end) ? (ch_end ? '0 : ch_q + HW'(1)) : ch_q;
            end else if (state_q == IDLE && start_i) begin
                base_q <= base_addr_i;
                off_q  <= '0;
                col_q  <= '0;
                row_q  <= '0;
                ch_q   <= '0;
            end
        end
    end

    assign ready_o = state_q == RUN;
    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign col_o   = col_q;
    assign row_o   = row_q;
    assign ch_o    = ch_q;
    assign busy_o  = (state_q == RUN) | we_q;
    assign done_o  = done_q;
endmodule
